character_state_controller: RTL and testbench

CHARACTER_STATE_CONTROLLER -- requirements
Module: character_state_controller

---
 rtl/character_state_controller_pkg.sv | 45 ++++
 rtl/character_state_controller_vel_integrator.sv | 34 +++
 rtl/character_state_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_character_state_controller.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/character_state_controller_pkg.sv
// -----------------------------------------------------------------------------
// character_state_controller_pkg
// Shared definitions for the character movement controller and the downstream
// display-state block: state encoding, default physics constants and a small
// clamp helper used to form the launch velocity.
// -----------------------------------------------------------------------------
package character_state_controller_pkg;

  // Character state encoding (3 bits, also decoded by the display block)
  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_LEFT           = 3'd1,
    ST_RIGHT          = 3'd2,
    ST_CHARGE         = 3'd3,
    ST_JUMP           = 3'd4,
    ST_COLLISION      = 3'd5,
    ST_FALL_TO_GROUND = 3'd6,
    ST_HOLD           = 3'd7
  } char_state_e;

  // Default physics constants
  localparam int DEF_SIGNED_PHY_WIDTH = 17;
  localparam int DEF_MAX_VEL_Y        = 10;
  localparam int DEF_GRAVITY          = 1;
  localparam int DEF_WALK_VEL         = 2;
  localparam int DEF_JUMP_VEL_X       = 3;
  localparam int DEF_MAX_CHARGE       = 40;
  localparam int DEF_CHARGE_SHIFT     = 2;

  // Clamp a non-negative magnitude into [lo, hi]
  function automatic int unsigned clamp_launch(input int unsigned raw,
                                               input int unsigned lo,
                                               input int unsigned hi);
    int unsigned res;
    if (raw < lo) begin
      res = lo;
    end else if (raw > hi) begin
      res = hi;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage

// File: rtl/character_state_controller_vel_integrator.sv
// -----------------------------------------------------------------------------
// character_vel_integrator
// Combinational vertical-velocity step: subtracts GRAVITY from vel_y and
// saturates at -MAX_VEL_Y so the result never wraps. The owning controller
// registers the result.
// Ports:
//   vel_y      in  W signed  current vertical velocity
//   vel_y_next out W signed  velocity after one airborne tick
// -----------------------------------------------------------------------------
module character_vel_integrator #(
  parameter int SIGNED_PHY_WIDTH = 17,
  parameter int MAX_VEL_Y        = 10,
  parameter int GRAVITY          = 1
) (
  input  logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_y_next
);

  localparam logic signed [SIGNED_PHY_WIDTH-1:0] GRAV_S  = SIGNED_PHY_WIDTH'(GRAVITY);
  localparam logic signed [SIGNED_PHY_WIDTH-1:0] FLOOR_S = -SIGNED_PHY_WIDTH'(MAX_VEL_Y);

  logic signed [SIGNED_PHY_WIDTH-1:0] diff;

  // Apply gravity and clamp to the terminal fall velocity
  always_comb begin
    diff = vel_y - GRAV_S;
    if (diff < FLOOR_S) begin
      vel_y_next = FLOOR_S;
    end else begin
      vel_y_next = diff;
    end
  end

endmodule

// File: rtl/character_state_controller.sv
// -----------------------------------------------------------------------------
// character_state_controller
// Platformer character movement FSM. Inputs are registered once; state and
// velocities advance only on sys_clk edges where the registered physics tick
// is high. Outputs come straight from flops.
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   character_clk               one-cycle physics tick strobe
//   btn_left/btn_right/btn_jump debounced buttons, active high
//   on_ground, hit_wall         collision sensing
//   char_state                  current state (see char_state_e)
//   vel_x, vel_y                signed velocities, +x right, +y up
//   facing                      0 = left, 1 = right
// -----------------------------------------------------------------------------
module character_state_controller
  import character_state_controller_pkg::*;
#(
  parameter int SIGNED_PHY_WIDTH = DEF_SIGNED_PHY_WIDTH,
  parameter int MAX_VEL_Y        = DEF_MAX_VEL_Y,
  parameter int GRAVITY          = DEF_GRAVITY,
  parameter int WALK_VEL         = DEF_WALK_VEL,
  parameter int JUMP_VEL_X       = DEF_JUMP_VEL_X,
  parameter int MAX_CHARGE       = DEF_MAX_CHARGE,
  parameter int CHARGE_SHIFT     = DEF_CHARGE_SHIFT
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic                               character_clk,
  input  logic                               btn_left,
  input  logic                               btn_right,
  input  logic                               btn_jump,
  input  logic                               on_ground,
  input  logic                               hit_wall,
  output logic [2:0]                         char_state,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_x,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
  output logic                               facing
);

  localparam int W     = SIGNED_PHY_WIDTH;
  localparam int CNT_W = $clog2(MAX_CHARGE + 1);

  localparam logic signed [W-1:0] ZERO_S   = '0;
  localparam logic signed [W-1:0] WALK_S   = W'(WALK_VEL);
  localparam logic signed [W-1:0] JUMPX_S  = W'(JUMP_VEL_X);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(MAX_CHARGE);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  // Input synchronising stage
  logic tick_q, btn_left_q, btn_right_q, btn_jump_q, on_ground_q, hit_wall_q;

  // Architectural state
  char_state_e            state_q, state_d;
  logic signed [W-1:0]    vel_x_q, vel_x_d;
  logic signed [W-1:0]    vel_y_q, vel_y_d;
  logic                   facing_q, facing_d;
  logic [CNT_W-1:0]       charge_cnt_q, charge_cnt_d;

  logic                   go_left, go_right, landing;
  logic signed [W-1:0]    vel_y_grav;
  logic signed [W-1:0]    launch_vel;

  character_vel_integrator #(
    .SIGNED_PHY_WIDTH (W),
    .MAX_VEL_Y        (MAX_VEL_Y),
    .GRAVITY          (GRAVITY)
  ) u_vel_integrator (
    .vel_y      (vel_y_q),
    .vel_y_next (vel_y_grav)
  );

  // Both directions pressed cancel out; landing needs ground and no upward motion
  always_comb begin
    go_left    = btn_left_q & ~btn_right_q;
    go_right   = btn_right_q & ~btn_left_q;
    landing    = on_ground_q & (vel_y_q <= ZERO_S);
    launch_vel = W'(clamp_launch(int'(charge_cnt_q >> CHARGE_SHIFT), 32'd1,
                                 MAX_VEL_Y));
  end

  // Next-state and velocity computation, evaluated only on a physics tick
  always_comb begin
    state_d      = state_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    facing_d     = facing_q;
    charge_cnt_d = charge_cnt_q;
    if (tick_q) begin
      case (state_q)
        ST_IDLE, ST_LEFT, ST_RIGHT: begin
          vel_y_d = ZERO_S;
          if (!on_ground_q) begin
            // Walked off an edge: start falling from rest
            state_d = ST_JUMP;
            vel_x_d = ZERO_S;
          end else if (btn_jump_q) begin
            state_d      = ST_CHARGE;
            vel_x_d      = ZERO_S;
            charge_cnt_d = CNT_ONE;
          end else if (go_left) begin
            state_d  = ST_LEFT;
            vel_x_d  = -WALK_S;
            facing_d = 1'b0;
          end else if (go_right) begin
            state_d  = ST_RIGHT;
            vel_x_d  = WALK_S;
            facing_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            vel_x_d = ZERO_S;
          end
        end
        ST_CHARGE: begin
          vel_x_d = ZERO_S;
          if (!btn_jump_q || (charge_cnt_q == CNT_MAX)) begin
            state_d      = ST_JUMP;
            vel_y_d      = launch_vel;
            charge_cnt_d = '0;
            if (go_left) begin
              vel_x_d  = -JUMPX_S;
              facing_d = 1'b0;
            end else if (go_right) begin
              vel_x_d  = JUMPX_S;
              facing_d = 1'b1;
            end else begin
              vel_x_d = ZERO_S;
            end
          end else begin
            charge_cnt_d = charge_cnt_q + CNT_ONE;
          end
        end
        ST_JUMP: begin
          vel_y_d = vel_y_grav;
          if (landing) begin
            // Landing wins over a simultaneous wall hit
            state_d = ST_FALL_TO_GROUND;
            vel_x_d = ZERO_S;
          end else if (hit_wall_q) begin
            // Bounce is applied on entry so COLLISION shows the reversed motion
            state_d  = ST_COLLISION;
            vel_x_d  = -vel_x_q;
            facing_d = ~facing_q;
          end else begin
            state_d = ST_JUMP;
          end
        end
        ST_COLLISION: begin
          vel_y_d = vel_y_grav;
          if (landing) begin
            state_d = ST_FALL_TO_GROUND;
            vel_x_d = ZERO_S;
          end else begin
            state_d = ST_JUMP;
          end
        end
        ST_FALL_TO_GROUND: begin
          vel_x_d = ZERO_S;
          vel_y_d = ZERO_S;
          if (btn_jump_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          vel_x_d = ZERO_S;
          vel_y_d = ZERO_S;
          if (btn_jump_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          vel_x_d      = ZERO_S;
          vel_y_d      = ZERO_S;
          charge_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Input register stage and FSM/velocity state flops
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_q       <= 1'b0;
      btn_left_q   <= 1'b0;
      btn_right_q  <= 1'b0;
      btn_jump_q   <= 1'b0;
      on_ground_q  <= 1'b0;
      hit_wall_q   <= 1'b0;
      state_q      <= ST_IDLE;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      facing_q     <= 1'b1;
      charge_cnt_q <= '0;
    end else begin
      tick_q       <= character_clk;
      btn_left_q   <= btn_left;
      btn_right_q  <= btn_right;
      btn_jump_q   <= btn_jump;
      on_ground_q  <= on_ground;
      hit_wall_q   <= hit_wall;
      state_q      <= state_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      facing_q     <= facing_d;
      charge_cnt_q <= charge_cnt_d;
    end
  end

  assign char_state = state_q;
  assign vel_x      = vel_x_q;
  assign vel_y      = vel_y_q;
  assign facing     = facing_q;

endmodule

// File: tb/tb_character_state_controller.sv
// -----------------------------------------------------------------------------
// tb_character_state_controller
// Directed bench for character_state_controller with default parameters.
// Each physics tick is a one-cycle character_clk pulse; results are sampled
// on the falling edge after the update edge.
// -----------------------------------------------------------------------------
module tb_character_state_controller;

  localparam int W = 17;

  localparam int S_IDLE   = 0;
  localparam int S_LEFT   = 1;
  localparam int S_RIGHT  = 2;
  localparam int S_CHARGE = 3;
  localparam int S_JUMP   = 4;
  localparam int S_COLL   = 5;
  localparam int S_FTG    = 6;
  localparam int S_HOLD   = 7;

  logic                sys_clk;
  logic                sys_rst_n;
  logic                character_clk;
  logic                btn_left, btn_right, btn_jump, on_ground, hit_wall;
  logic [2:0]          char_state;
  logic signed [W-1:0] vel_x, vel_y;
  logic                facing;

  int checks;
  int errors;

  character_state_controller dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .character_clk (character_clk),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_jump      (btn_jump),
    .on_ground     (on_ground),
    .hit_wall      (hit_wall),
    .char_state    (char_state),
    .vel_x         (vel_x),
    .vel_y         (vel_y),
    .facing        (facing)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the update
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      character_clk = 1'b1;
      @(negedge sys_clk);
      character_clk = 1'b0;
      @(negedge sys_clk);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int vx,
                         input int vy, input int fc);
    chk({tag, "_state"},  char_state, st);
    chk({tag, "_vel_x"},  vel_x, vx);
    chk({tag, "_vel_y"},  vel_y, vy);
    chk({tag, "_facing"}, facing, fc);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    sys_rst_n     = 1'b0;
    character_clk = 1'b0;
    btn_left      = 1'b0;
    btn_right     = 1'b0;
    btn_jump      = 1'b0;
    on_ground     = 1'b1;
    hit_wall      = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_all("reset", S_IDLE, 0, 0, 1);
    sys_rst_n = 1'b1;

    // Both directions pressed: no movement
    btn_left = 1'b1; btn_right = 1'b1;
    tick(2);
    chk("both_dir_state", char_state, S_IDLE);
    chk("both_dir_vel_x", vel_x, 0);

    // Walking
    btn_left = 1'b0;
    tick(1);
    chk_all("walk_right", S_RIGHT, 2, 0, 1);
    btn_right = 1'b0; btn_left = 1'b1;
    tick(1);
    chk_all("walk_left", S_LEFT, -2, 0, 0);
    btn_left = 1'b0;
    tick(1);
    chk_all("walk_release", S_IDLE, 0, 0, 0);

    // 20-tick charge then release: launch 20>>2 = 5
    btn_jump = 1'b1;
    tick(1);
    chk("charge_enter", char_state, S_CHARGE);
    tick(19);
    chk("charge_20", char_state, S_CHARGE);
    btn_jump = 1'b0;
    tick(1);
    chk_all("launch5", S_JUMP, 0, 5, 0);
    on_ground = 1'b0;
    tick(5);
    chk_all("apex5", S_JUMP, 0, 0, 0);
    on_ground = 1'b1;
    tick(1);
    chk_all("land5", S_FTG, 0, -1, 0);
    tick(1);
    chk_all("land5_idle", S_IDLE, 0, 0, 0);

    // Held charge saturates: forced launch at 40 -> vel_y 10
    btn_jump = 1'b1;
    tick(40);
    chk("charge_sat", char_state, S_CHARGE);
    tick(1);
    chk_all("launch10", S_JUMP, 0, 10, 0);
    on_ground = 1'b0;
    tick(10);
    chk("fall_mid_vel_y", vel_y, 0);
    tick(10);
    chk("fall_floor_vel_y", vel_y, -10);
    tick(5);
    chk_all("fall_sat", S_JUMP, 0, -10, 0);
    on_ground = 1'b1;
    tick(1);
    chk_all("land10", S_FTG, 0, -10, 0);
    tick(1);
    chk_all("hold", S_HOLD, 0, 0, 0);
    btn_left = 1'b1;
    tick(1);
    chk_all("hold_dir", S_HOLD, 0, 0, 0);
    btn_left = 1'b0; btn_jump = 1'b0;
    tick(1);
    chk_all("hold_release", S_IDLE, 0, 0, 0);

    // Right jump with wall bounce
    btn_right = 1'b1; btn_jump = 1'b1;
    tick(1);
    chk("rj_charge", char_state, S_CHARGE);
    btn_jump = 1'b0;
    tick(1);
    chk_all("rj_launch", S_JUMP, 3, 1, 1);
    on_ground = 1'b0;
    tick(2);
    chk_all("rj_air", S_JUMP, 3, -1, 1);
    hit_wall = 1'b1;
    tick(1);
    chk_all("collision", S_COLL, -3, -2, 0);
    hit_wall = 1'b0;
    tick(1);
    chk_all("post_coll", S_JUMP, -3, -3, 0);

    // Ground and wall together: landing wins
    on_ground = 1'b1; hit_wall = 1'b1;
    tick(1);
    chk_all("land_prio", S_FTG, 0, -4, 0);
    hit_wall = 1'b0; btn_right = 1'b0;
    tick(1);
    chk_all("land_prio_idle", S_IDLE, 0, 0, 0);

    // Walking off an edge
    on_ground = 1'b0;
    tick(1);
    chk_all("edge_fall", S_JUMP, 0, 0, 0);
    tick(1);
    chk("edge_fall_vel_y", vel_y, -1);
    on_ground = 1'b1;
    tick(1);
    chk_all("edge_land", S_FTG, 0, -2, 0);
    tick(1);
    chk("edge_idle", char_state, S_IDLE);

    // Asynchronous reset mid-jump
    btn_left = 1'b1; btn_jump = 1'b1;
    tick(1);
    btn_jump = 1'b0;
    tick(1);
    chk_all("lj_launch", S_JUMP, -3, 1, 0);
    on_ground = 1'b0;
    tick(2);
    chk_all("lj_air", S_JUMP, -3, -1, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_all("async_reset", S_IDLE, 0, 0, 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    btn_left  = 1'b0;
    on_ground = 1'b1;
    tick(1);
    chk_all("post_reset", S_IDLE, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
